// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaler plus N_CH software-style tick timers
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   en                  global run enable (0 freezes prescaler and counts)
//   cfg_valid/ready     config handshake, accepted when both are 1 on an edge
//   cfg_op              00 nop, 01 start, 10 stop, 11 reserved (nop)
//   cfg_ch              target channel
//   cfg_period          period in base ticks (start only)
//   cfg_periodic        1 auto-reload, 0 one-shot (start only)
//   cfg_err             one-clock pulse: start requested with period 0
//   tick                one-clock pulse per base tick
//   expire              per-channel one-clock expiry pulse, coincident with tick
//   active              per-channel running flag
//   rd_ch / rd_count    combinational readback of a channel's remaining count
module tick_scheduler #(
    parameter int CLK_DIV = 50000,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [1:0]             cfg_op,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [CNT_W-1:0]       cfg_period,
    input  logic                   cfg_periodic,
    output logic                   cfg_err,
    output logic                   tick,
    output logic [(1<<CH_W)-1:0]   expire,
    output logic [(1<<CH_W)-1:0]   active,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [CNT_W-1:0]       rd_count
);

    localparam int N_CH = 1 << CH_W;
    localparam int PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;

    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] count  [N_CH];
    logic [CNT_W-1:0] reload [N_CH];
    logic [N_CH-1:0]  periodic;

    logic tc;
    logic accept;
    logic do_start;
    logic do_kill;
    logic start_zero;

    // Terminal-count cycle: the edge closing this cycle is the tick edge.
    assign tc = en && (presc == PRESC_MAX);

    // Config writes are blocked in the TC cycle so they never race the
    // tick update; held low combinationally while reset is asserted.
    assign cfg_ready = reset && !tc;
    assign accept    = cfg_valid && cfg_ready;

    assign start_zero = accept && (cfg_op == OP_START) && (cfg_period == '0);
    assign do_start   = accept && (cfg_op == OP_START) && (cfg_period != '0);
    // A zero-period start is treated as a forced stop of the target channel.
    assign do_kill    = (accept && (cfg_op == OP_STOP)) || start_zero;

    assign rd_count = count[rd_ch];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            tick    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            tick    <= tc;
            cfg_err <= start_zero;
            if (en) begin
                presc <= tc ? '0 : presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expire   <= '0;
            active   <= '0;
            periodic <= '0;
            for (int i = 0; i < N_CH; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                expire[i] <= tc && active[i] && (count[i] == CNT_W'(1));
                // accept and tc are mutually exclusive, so the tick update
                // and a config write can never target the same edge.
                if (tc) begin
                    if (active[i]) begin
                        if (count[i] == CNT_W'(1)) begin
                            if (periodic[i]) begin
                                count[i] <= reload[i];
                            end else begin
                                count[i]  <= '0;
                                active[i] <= 1'b0;
                            end
                        end else begin
                            count[i] <= count[i] - CNT_W'(1);
                        end
                    end
                end else if (cfg_ch == CH_W'(i)) begin
                    if (do_start) begin
                        count[i]    <= cfg_period;
                        reload[i]   <= cfg_period;
                        periodic[i] <= cfg_periodic;
                        active[i]   <= 1'b1;
                    end else if (do_kill) begin
                        count[i]  <= '0;
                        active[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_op;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_periodic;
    logic        cfg_err;
    logic        tick;
    logic [3:0]  expire;
    logic [3:0]  active;
    logic [1:0]  rd_ch;
    logic [15:0] rd_count;

    int vectors = 0;
    int miscompares = 0;

    tick_scheduler #(.CLK_DIV(4), .CH_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
        .cfg_err(cfg_err), .tick(tick), .expire(expire), .active(active),
        .rd_ch(rd_ch), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_op = 2'b00; cfg_ch = 2'd0;
        cfg_period = 16'd0; cfg_periodic = 1'b0; rd_ch = 2'd0;
        cyc; cyc;
        reset = 1'b1;
    endtask

    task automatic send_cfg(input logic [1:0] op, input logic [1:0] ch,
                            input logic [15:0] per, input logic pm);
        cfg_valid = 1'b1; cfg_op = op; cfg_ch = ch; cfg_period = per; cfg_periodic = pm;
    endtask

    // Next edge after reset release is edge 1; tick follows edges 4, 8, 12.
    task automatic idle_check(input string tag);
        for (int k = 1; k <= 12; k++) begin
            cyc;
            vectors++;
            if (tick !== (k % 4 == 0)) begin miscompares++; $display("FAIL %s_tick edge=%0d got %0b exp %0b", tag, k, tick, (k % 4 == 0)); end
            vectors++;
            if (expire !== 4'b0 || active !== 4'b0) begin miscompares++; $display("FAIL %s_idle edge=%0d got exp=%0h act=%0h exp 0", tag, k, expire, active); end
        end
    endtask

    task automatic test_reset;
        do_reset;
        reset = 1'b0;
        cyc;
        vectors++;
        if ({tick, cfg_err, cfg_ready} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %0b exp 000", {tick, cfg_err, cfg_ready}); end
        vectors++;
        if (expire !== 4'b0 || active !== 4'b0 || rd_count !== 16'd0) begin miscompares++; $display("FAIL reset_state got %0h/%0h/%0h exp 0", expire, active, rd_count); end
        reset = 1'b1;
        idle_check("reset");
    endtask

    task automatic test_oneshot;
        logic [15:0] ec;
        do_reset;
        send_cfg(OP_START, 2'd0, 16'd3, 1'b0);
        for (int k = 1; k <= 52; k++) begin
            cyc;
            if (k == 1) cfg_valid = 1'b0;
            ec = (k < 4) ? 16'd3 : (k < 8) ? 16'd2 : (k < 12) ? 16'd1 : 16'd0;
            vectors++;
            if (rd_count !== ec) begin miscompares++; $display("FAIL oneshot_count edge=%0d got %0d exp %0d", k, rd_count, ec); end
            vectors++;
            if (expire !== ((k == 12) ? 4'b0001 : 4'b0000)) begin miscompares++; $display("FAIL oneshot_expire edge=%0d got %0h", k, expire); end
            vectors++;
            if (active[0] !== (k < 12)) begin miscompares++; $display("FAIL oneshot_active edge=%0d got %0b exp %0b", k, active[0], (k < 12)); end
        end
    endtask

    task automatic test_periodic;
        logic [3:0] e;
        do_reset;
        send_cfg(OP_START, 2'd1, 16'd2, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            cyc;
            if (k == 1) send_cfg(OP_START, 2'd2, 16'd5, 1'b1);
            if (k == 2) cfg_valid = 1'b0;
            e = 4'b0;
            e[1] = (k % 8 == 0);
            e[2] = (k % 20 == 0);
            vectors++;
            if (expire !== e) begin miscompares++; $display("FAIL periodic_expire edge=%0d got %0h exp %0h", k, expire, e); end
            if (k >= 2) begin
                vectors++;
                if (active !== 4'b0110) begin miscompares++; $display("FAIL periodic_active edge=%0d got %0h exp 6", k, active); end
            end
        end
    endtask

    task automatic test_ready_tc;
        do_reset;
        cyc; cyc; cyc;
        send_cfg(OP_START, 2'd3, 16'd7, 1'b1);
        rd_ch = 2'd3;
        #1;
        vectors++;
        if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL tc_ready got %0b exp 0", cfg_ready); end
        cyc;
        vectors++;
        if ({tick, active[3], cfg_ready} !== 3'b101) begin miscompares++; $display("FAIL tc_hold got %0b exp 101", {tick, active[3], cfg_ready}); end
        cyc;
        cfg_valid = 1'b0;
        vectors++;
        if (active[3] !== 1'b1 || rd_count !== 16'd7) begin miscompares++; $display("FAIL tc_accept got act=%0b cnt=%0d exp 1/7", active[3], rd_count); end
        for (int k = 6; k <= 8; k++) begin
            cyc;
            vectors++;
            if (rd_count !== ((k < 8) ? 16'd7 : 16'd6)) begin miscompares++; $display("FAIL tc_count edge=%0d got %0d", k, rd_count); end
        end
    endtask

    task automatic test_err_stop_freeze;
        do_reset;
        send_cfg(OP_START, 2'd0, 16'd5, 1'b1);
        cyc;
        send_cfg(OP_START, 2'd0, 16'd0, 1'b0);
        cyc;
        vectors++;
        if (cfg_err !== 1'b1 || active[0] !== 1'b0 || rd_count !== 16'd0) begin miscompares++; $display("FAIL err_pulse got err=%0b act=%0b cnt=%0d exp 1/0/0", cfg_err, active[0], rd_count); end
        send_cfg(OP_START, 2'd1, 16'd3, 1'b1);
        cyc;
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_err !== 1'b0 || active[1] !== 1'b1) begin miscompares++; $display("FAIL err_clear got err=%0b act=%0b exp 0/1", cfg_err, active[1]); end
        repeat (5) cyc;
        send_cfg(OP_STOP, 2'd1, 16'd0, 1'b0);
        rd_ch = 2'd1;
        cyc;
        cfg_valid = 1'b0;
        vectors++;
        if (active[1] !== 1'b0 || rd_count !== 16'd0) begin miscompares++; $display("FAIL stop got act=%0b cnt=%0d exp 0/0", active[1], rd_count); end
        for (int k = 10; k <= 16; k++) begin
            cyc;
            vectors++;
            if (expire !== 4'b0) begin miscompares++; $display("FAIL stop_noexpire edge=%0d got %0h", k, expire); end
        end
        send_cfg(OP_START, 2'd2, 16'd4, 1'b0);
        rd_ch = 2'd2;
        cyc;
        cfg_valid = 1'b0;
        repeat (8) cyc;
        vectors++;
        if (rd_count !== 16'd2) begin miscompares++; $display("FAIL freeze_pre got %0d exp 2", rd_count); end
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            cyc;
            vectors++;
            if (tick !== 1'b0 || rd_count !== 16'd2 || cfg_ready !== 1'b1) begin miscompares++; $display("FAIL freeze cyc=%0d got tick=%0b cnt=%0d rdy=%0b", j, tick, rd_count, cfg_ready); end
        end
        en = 1'b1;
        cyc; cyc; cyc;
        vectors++;
        if (tick !== 1'b1 || rd_count !== 16'd1) begin miscompares++; $display("FAIL resume got tick=%0b cnt=%0d exp 1/1", tick, rd_count); end
        repeat (4) cyc;
        vectors++;
        if (expire !== 4'b0100 || active !== 4'b0000) begin miscompares++; $display("FAIL resume_expire got %0h/%0h exp 4/0", expire, active); end
    endtask

    task automatic test_async_reset;
        do_reset;
        send_cfg(OP_START, 2'd1, 16'd2, 1'b1);
        rd_ch = 2'd1;
        cyc;
        cfg_valid = 1'b0;
        repeat (7) cyc;
        vectors++;
        if (tick !== 1'b1 || expire !== 4'b0010 || rd_count !== 16'd2) begin miscompares++; $display("FAIL arst_pre got tick=%0b exp=%0h cnt=%0d", tick, expire, rd_count); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({tick, cfg_ready} !== 2'b00 || expire !== 4'b0 || active !== 4'b0 || rd_count !== 16'd0) begin
            miscompares++; $display("FAIL arst_clear got tick=%0b rdy=%0b exp=%0h act=%0h cnt=%0d", tick, cfg_ready, expire, active, rd_count);
        end
        cyc; cyc;
        reset = 1'b1;
        idle_check("arst");
    endtask

    initial begin
        test_reset;
        test_oneshot;
        test_periodic;
        test_ready_tc;
        test_err_stop_freeze;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
